branch_jump_unit: RTL

- Producer side of the program counter's redirect interface: decodes the current MIPS32 instruction and resolves branches and jumps against register operands.
- Drives the PC's jump_enable/jump_input pair, honouring the architectural branch delay slot.
- Generates the link-register write for JAL/JALR/BLTZAL/BGEZAL.
- Sits between decode/register-file read and the program_counter in the single-cycle datapath.

---
 rtl/branch_jump_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/branch_jump_unit.sv
// MIPS32 branch/jump resolution and PC redirect generation, with an optional
// architectural delay slot and link-register write generation.
module branch_jump_unit #(
  parameter int DELAY_SLOT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic [29:0] pc_value,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        jump_enable,
  output logic [29:0] jump_input,
  output logic        link_enable,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        in_delay_slot
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [29:0] pc1;
  logic [29:0] pc2;
  logic [29:0] branch_target;
  logic [29:0] jump_target;
  logic        taken;
  logic [29:0] target;
  logic        link_req;
  logic [4:0]  link_dest;
  logic        suppress;
  logic        accept;
  logic        unused_ok;

  assign pc1           = 30'(pc_value + 30'd1);
  assign pc2           = 30'(pc_value + 30'd2);
  assign branch_target = 30'(pc1 + {{14{instruction[15]}}, instruction[15:0]});
  assign jump_target   = {pc1[29:26], instruction[25:0]};
  // The rs field and shamt are not needed: operands arrive already read.
  assign unused_ok     = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    taken     = 1'b0;
    target    = branch_target;
    link_req  = 1'b0;
    link_dest = 5'd0;
    case (instruction[31:26])
      OP_J: begin
        taken  = 1'b1;
        target = jump_target;
      end
      OP_JAL: begin
        taken     = 1'b1;
        target    = jump_target;
        link_req  = 1'b1;
        link_dest = 5'd31;
      end
      OP_BEQ:  taken = (rs_data == rt_data);
      OP_BNE:  taken = (rs_data != rt_data);
      OP_BLEZ: taken = rs_data[31] || (rs_data == 32'd0);
      OP_BGTZ: taken = !rs_data[31] && (rs_data != 32'd0);
      OP_REGIMM: begin
        case (instruction[20:16])
          5'b00000: taken = rs_data[31];
          5'b00001: taken = !rs_data[31];
          5'b10000: begin
            taken     = rs_data[31];
            link_req  = 1'b1;
            link_dest = 5'd31;
          end
          5'b10001: begin
            taken     = !rs_data[31];
            link_req  = 1'b1;
            link_dest = 5'd31;
          end
          default: ;
        endcase
      end
      OP_SPECIAL: begin
        case (instruction[5:0])
          FN_JR: begin
            taken  = 1'b1;
            target = rs_data[31:2];
          end
          FN_JALR: begin
            taken     = 1'b1;
            target    = rs_data[31:2];
            link_req  = (instruction[15:11] != 5'd0);
            link_dest = instruction[15:11];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign accept      = instr_valid && !reset && !suppress;
  assign link_enable = accept && link_req;
  assign link_reg    = link_dest;
  assign link_data   = {((DELAY_SLOT != 0) ? pc2 : pc1), 2'b00};

  generate
    if (DELAY_SLOT != 0) begin : g_delay
      typedef enum logic {IDLE, PENDING} state_t;
      state_t      state_reg, state_next;
      logic [29:0] target_reg, target_next;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg  <= IDLE;
          target_reg <= '0;
        end else begin
          state_reg  <= state_next;
          target_reg <= target_next;
        end
      end

      // PENDING always lasts one cycle; transfers seen there are delay-slot
      // instructions and are dropped via suppress.
      always_comb begin
        state_next  = IDLE;
        target_next = target_reg;
        if (state_reg == IDLE && accept && taken) begin
          state_next  = PENDING;
          target_next = target;
        end
      end

      assign suppress      = (state_reg == PENDING);
      assign jump_enable   = (state_reg == PENDING) && !reset;
      assign jump_input    = target_reg;
      assign in_delay_slot = (state_reg == PENDING) && !reset;
    end else begin : g_comb
      assign suppress      = 1'b0;
      assign jump_enable   = accept && taken;
      assign jump_input    = target;
      assign in_delay_slot = 1'b0;
    end
  endgenerate

endmodule
